// File: rtl/vga_compositor.sv
// rtl/vga_compositor.sv - two-stage VGA layer compositor with optional collision flag (COMPOSITOR_COLLISION_EN)
module vga_compositor #(
    parameter int NUM_SPRITES = 2,
    parameter int SPRITE_W    = 128,
    parameter int SPRITE_H    = 128,
    parameter int ADDR_W      = 14,
    parameter int GROUND_V    = 394
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        bright,
    input  logic [9:0]                  hCount,
    input  logic [9:0]                  vCount,
    input  logic [10*NUM_SPRITES-1:0]   sprite_x,
    input  logic [10*NUM_SPRITES-1:0]   sprite_y,
    output logic [ADDR_W*NUM_SPRITES-1:0] sprite_addr,
    input  logic [12*NUM_SPRITES-1:0]   sprite_pixel,
    input  logic                        hud_valid,
    input  logic [11:0]                 hud_pixel,
    output logic [11:0]                 rgb,
    output logic                        collision
);

    localparam logic [10:0] SW11 = 11'(SPRITE_W);
    localparam logic [10:0] SH11 = 11'(SPRITE_H);
    localparam logic [31:0] SW32 = 32'(SPRITE_W);
    localparam logic [9:0]  GROUND = 10'(GROUND_V);

    logic [NUM_SPRITES-1:0] region;
    logic [NUM_SPRITES-1:0] region_q;
    logic [NUM_SPRITES-1:0] opaque;
    logic                   bright_q;
    logic [9:0]             h_q;
    logic [9:0]             v_q;
    logic [11:0]            background;
    logic [11:0]            rgb_next;
    logic [3:0]             sky_b;
    logic [3:0]             ground_g;

    // Region test and ROM address per sprite; 11-bit compares keep edge+size from wrapping
    always_comb begin
        logic [10:0] sx, sy;
        logic [9:0]  dx, dy;
        region      = '0;
        sprite_addr = '0;
        sx = '0;
        sy = '0;
        dx = '0;
        dy = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            sx = {1'b0, sprite_x[10*i +: 10]};
            sy = {1'b0, sprite_y[10*i +: 10]};
            dx = hCount - sprite_x[10*i +: 10];
            dy = vCount - sprite_y[10*i +: 10];
            region[i] = ({1'b0, hCount} >= sx) && ({1'b0, hCount} < sx + SW11) &&
                        ({1'b0, vCount} >= sy) && ({1'b0, vCount} < sy + SH11);
            if (region[i])
                sprite_addr[ADDR_W*i +: ADDR_W] = ADDR_W'((32'(dy) * SW32) + 32'(dx));
        end
    end

    // Stage 1: hold scan position and region bits while ROM and HUD data return
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            bright_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            region_q <= '0;
        end else begin
            bright_q <= bright;
            h_q      <= hCount;
            v_q      <= vCount;
            region_q <= region;
        end
    end

    // Opaque-in-region per sprite; 00C/00D/00F are the transparent keys
    always_comb begin
        logic [11:0] p;
        opaque = '0;
        p = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            p = sprite_pixel[12*i +: 12];
            opaque[i] = region_q[i] && (p != 12'h00C) && (p != 12'h00D) && (p != 12'h00F);
        end
    end

    // Background: blue sky gradient saturating at 15, green checker ground below
    always_comb begin
        sky_b      = (v_q[9:8] != 2'b00) ? 4'hF : v_q[7:4];
        ground_g   = (h_q[4] ^ v_q[3]) ? 4'd12 : 4'd8;
        background = (v_q < GROUND) ? {8'h00, sky_b} : {4'h0, ground_g, 4'h1};
    end

    // Layer priority: blanking, HUD, lowest-index opaque sprite, background
    always_comb begin
        rgb_next = background;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i])
                rgb_next = sprite_pixel[12*i +: 12];
        end
        if (hud_valid)
            rgb_next = hud_pixel;
        if (!bright_q)
            rgb_next = 12'h000;
    end

    // Stage 2: registered output colour
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            rgb <= 12'h000;
        else
            rgb <= rgb_next;
    end

`ifdef COMPOSITOR_COLLISION_EN
    logic sticky;
    logic overlap;

    assign overlap = bright_q && ($countones(opaque) > 1);

    // Sticky overlap for the current frame, published to collision at the next frame start
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sticky    <= 1'b0;
            collision <= 1'b0;
        end else if (h_q == 10'd0 && v_q == 10'd0) begin
            collision <= sticky;
            sticky    <= overlap;
        end else begin
            sticky    <= sticky | overlap;
        end
    end
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_vga_compositor.sv
// tb/tb_vga_compositor.sv - table-driven scoreboard bench for vga_compositor
module tb_vga_compositor;

    localparam logic [9:0] FAR = 10'd1000;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        bright;
    logic [9:0]  hCount, vCount;
    logic [19:0] sprite_x, sprite_y;
    logic [27:0] sprite_addr;
    logic [23:0] sprite_pixel;
    logic        hud_valid;
    logic [11:0] hud_pixel;
    logic [11:0] rgb;
    logic        collision;

    vga_compositor dut (
        .clk(clk), .rst_l(rst_l), .bright(bright), .hCount(hCount), .vCount(vCount),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_addr(sprite_addr),
        .sprite_pixel(sprite_pixel), .hud_valid(hud_valid), .hud_pixel(hud_pixel),
        .rgb(rgb), .collision(collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        b;
        logic [9:0]  h, v, x0, y0, x1, y1;
        logic [11:0] p0, p1;
        logic        hv;
        logic [11:0] hp;
        logic [13:0] a0, a1;
        logic [11:0] rgb;
    } vec_t;

    typedef struct packed {
        logic        chk;
        logic [11:0] rgb;
    } exp_t;

    vec_t        tbl [19];
    exp_t        exp_q [$];
    logic [23:0] pend_pix;
    logic        pend_hv;
    logic [11:0] pend_hp;
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(input logic b, input logic [9:0] h, v, x0, y0, x1, y1,
                                input logic [11:0] p0, p1, input logic hv, input logic [11:0] hp,
                                input logic [13:0] a0, a1, input logic [11:0] rgb_e);
        vec_t t;
        t.b = b; t.h = h; t.v = v; t.x0 = x0; t.y0 = y0; t.x1 = x1; t.y1 = y1;
        t.p0 = p0; t.p1 = p1; t.hv = hv; t.hp = hp; t.a0 = a0; t.a1 = a1; t.rgb = rgb_e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Drive one scan position; ROM/HUD data for the previous position returns in the same cycle
    task automatic step(input vec_t t);
        exp_t e;
        @(negedge clk);
        sprite_pixel = pend_pix;
        hud_valid    = pend_hv;
        hud_pixel    = pend_hp;
        bright       = t.b;
        hCount       = t.h;
        vCount       = t.v;
        sprite_x     = {t.x1, t.x0};
        sprite_y     = {t.y1, t.y0};
        pend_pix     = {t.p1, t.p0};
        pend_hv      = t.hv;
        pend_hp      = t.hp;
        #1;
        chk("sprite_addr_0", 32'(sprite_addr[13:0]), 32'(t.a0));
        chk("sprite_addr_1", 32'(sprite_addr[27:14]), 32'(t.a1));
        exp_q.push_back('{chk: 1'b1, rgb: t.rgb});
        @(posedge clk);
        #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            if (e.chk)
                chk("rgb", 32'(rgb), 32'(e.rgb));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        pend_pix = '0;
        pend_hv  = 1'b0;
        pend_hp  = '0;
        rst_l = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l = 1'b0; bright = 1'b0; hCount = '0; vCount = '0;
        sprite_x = {FAR, FAR}; sprite_y = {FAR, FAR};
        sprite_pixel = '0; hud_valid = 1'b0; hud_pixel = '0;
        pend_pix = '0; pend_hv = 1'b0; pend_hp = '0;

        tbl[0]  = mk(1, 100, 200, 100, 200, FAR, FAR, 12'hF00, 12'h000, 0, 12'h000, 14'd0,     14'd0,   12'hF00);
        tbl[1]  = mk(1,  99, 200, 100, 200, FAR, FAR, 12'hF00, 12'h000, 0, 12'h000, 14'd0,     14'd0,   12'h00C);
        tbl[2]  = mk(1, 227, 327, 100, 200, FAR, FAR, 12'h0A0, 12'h000, 0, 12'h000, 14'd16383, 14'd0,   12'h0A0);
        tbl[3]  = mk(1, 228, 200, 100, 200, FAR, FAR, 12'hF00, 12'h000, 0, 12'h000, 14'd0,     14'd0,   12'h00C);
        tbl[4]  = mk(1, 100, 327, 100, 200, FAR, FAR, 12'hF00, 12'h000, 0, 12'h000, 14'd16256, 14'd0,   12'hF00);
        tbl[5]  = mk(1, 100, 328, 100, 200, FAR, FAR, 12'hF00, 12'h000, 0, 12'h000, 14'd0,     14'd0,   12'h00F);
        tbl[6]  = mk(1, 300, 300, 300, 300, 300, 300, 12'hF00, 12'h0F0, 0, 12'h000, 14'd0,     14'd0,   12'hF00);
        tbl[7]  = mk(1, 300, 300, 300, 300, 300, 300, 12'h00D, 12'h0F0, 0, 12'h000, 14'd0,     14'd0,   12'h0F0);
        tbl[8]  = mk(1, 300, 300, 300, 300, 300, 300, 12'h00C, 12'h00F, 0, 12'h000, 14'd0,     14'd0,   12'h00F);
        tbl[9]  = mk(1, 310, 305, 300, 300, 300, 300, 12'hF00, 12'h0F0, 1, 12'hFFF, 14'd650,   14'd650, 12'hFFF);
        tbl[10] = mk(0, 310, 305, 300, 300, 300, 300, 12'hF00, 12'h0F0, 1, 12'hFFF, 14'd650,   14'd650, 12'h000);
        tbl[11] = mk(1,   5, 100, FAR,   0, FAR, FAR, 12'hF00, 12'h000, 0, 12'h000, 14'd0,     14'd0,   12'h006);
        tbl[12] = mk(1, 1010, 50, FAR,   0, FAR, FAR, 12'hF00, 12'h000, 0, 12'h000, 14'd6410,  14'd0,   12'hF00);
        tbl[13] = mk(1,   0, 400, FAR, FAR, FAR, FAR, 12'hF00, 12'hF00, 0, 12'h000, 14'd0,     14'd0,   12'h081);
        tbl[14] = mk(1,  16, 400, FAR, FAR, FAR, FAR, 12'hF00, 12'hF00, 0, 12'h000, 14'd0,     14'd0,   12'h0C1);
        tbl[15] = mk(1,  16, 408, FAR, FAR, FAR, FAR, 12'hF00, 12'hF00, 0, 12'h000, 14'd0,     14'd0,   12'h081);
        tbl[16] = mk(1,   0, 393, FAR, FAR, FAR, FAR, 12'hF00, 12'hF00, 0, 12'h000, 14'd0,     14'd0,   12'h00F);
        tbl[17] = mk(1,   0, 239, FAR, FAR, FAR, FAR, 12'hF00, 12'hF00, 0, 12'h000, 14'd0,     14'd0,   12'h00E);
        tbl[18] = mk(1,  60,  61, FAR, FAR,  50,  60, 12'h000, 12'h456, 0, 12'h000, 14'd0,     14'd138, 12'h456);

        do_reset();
        chk("rgb_reset", 32'(rgb), 32'h000);
        chk("collision_reset", 32'(collision), 32'h0);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i]);
            chk("collision_idle", 32'(collision), 32'h0);
        end
        step(tbl[0]);

        // Asynchronous reset between clock edges, then pipeline refill
        @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        chk("rgb_async_reset", 32'(rgb), 32'h000);
        chk("collision_async_reset", 32'(collision), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        pend_pix = '0; pend_hv = 1'b0; pend_hp = '0;
        rst_l = 1'b1;
        step(tbl[1]);
        chk("rgb_first_after_release", 32'(rgb), 32'h000);
        step(tbl[0]);
        step(tbl[13]);
        step(tbl[14]);

`ifdef COMPOSITOR_COLLISION_EN
        begin
            vec_t fs;
            fs = mk(0, 0, 0, FAR, FAR, FAR, FAR, 12'h000, 12'h000, 0, 12'h000, 14'd0, 14'd0, 12'h000);
            do_reset();
            step(fs);
            step(tbl[6]);
            step(tbl[14]);
            step(fs);
            chk("collision_before_load", 32'(collision), 32'h0);
            step(tbl[14]);
            chk("collision_frame_n1", 32'(collision), 32'h1);
            step(tbl[13]);
            chk("collision_frame_n1_hold", 32'(collision), 32'h1);
            step(fs);
            chk("collision_frame_n1_end", 32'(collision), 32'h1);
            step(tbl[14]);
            chk("collision_frame_n2", 32'(collision), 32'h0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_compositor.md
VGA_COMPOSITOR -- requirements
Module: vga_compositor

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 2, number of sprite layers.
REQ-002 SHALL have parameter SPRITE_W, default 128, sprite width in pixels (power of two).
REQ-003 SHALL have parameter SPRITE_H, default 128, sprite height in pixels (power of two).
REQ-004 SHALL have parameter ADDR_W, default 14, per-sprite ROM address width, equal to log2(SPRITE_W*SPRITE_H).
REQ-005 SHALL have parameter GROUND_V, default 394, first scanline of the ground band.
REQ-006 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-007 SHALL have port rst_l  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port bright  input  1  visible-area flag from the VGA timing block.
REQ-009 SHALL have ports hCount, vCount  input  10 each  current scan position.
REQ-010 SHALL have port sprite_x  input  10*NUM_SPRITES  packed sprite left edges; slot i is bits [10i+9:10i].
REQ-011 SHALL have port sprite_y  input  10*NUM_SPRITES  packed sprite top edges; packed as sprite_x.
REQ-012 SHALL have port sprite_addr  output  ADDR_W*NUM_SPRITES  combinational ROM addresses.
REQ-013 SHALL have port sprite_pixel  input  12*NUM_SPRITES  ROM data, valid one clock after sprite_addr.
REQ-014 SHALL have ports hud_valid (input 1) and hud_pixel (input 12), HUD overlay pixel for the current hCount/vCount, valid one clock later.
REQ-015 SHALL have port rgb  output  12  registered pixel colour.
REQ-016 SHALL have port collision  output  1  per-frame sprite overlap flag.

Function
REQ-017 Sprite i region SHALL be sprite_x_i <= hCount < sprite_x_i+SPRITE_W and sprite_y_i <= vCount < sprite_y_i+SPRITE_H, with comparisons 11 bits wide so edge+size never wraps.
REQ-018 sprite_addr_i SHALL be (vCount-sprite_y_i)*SPRITE_W + (hCount-sprite_x_i), truncated to ADDR_W, inside the region; 0 outside.
REQ-019 Stage 1 SHALL register bright, hCount, vCount and every region bit, aligned with returning sprite_pixel and hud_pixel.
REQ-020 A sprite pixel SHALL be transparent when equal to 12'h00C, 12'h00D or 12'h00F.
REQ-021 Stage 2 SHALL register rgb by priority: !bright -> 12'h000; hud_valid -> hud_pixel; lowest-index sprite in region and opaque -> its pixel; vCount < GROUND_V -> sky; else ground.
REQ-022 Sky SHALL be R=0, G=0, B = (vCount>>4 > 15) ? 15 : vCount[7:4].
REQ-023 Ground SHALL be R=0, G = 8 + (hCount[4]^vCount[3] ? 4 : 0), B=1.
REQ-024 Latency from hCount/vCount to rgb SHALL be exactly 2 clocks; the block SHALL NOT stall.
REQ-025 With NUM_SPRITES=1, rgb SHALL be identical to a 2-stage-delayed single-sprite compositor.

Reset
REQ-026 On rst_l low, asynchronously: rgb=12'h000, collision=0, all pipeline registers and the sticky overlap bit cleared.
REQ-027 Reset mid-frame SHALL produce black until two clocks after release; collision stays 0 until the next complete frame.

Configuration
REQ-028 Macro COMPOSITOR_COLLISION_EN SHALL compile in collision detection.
REQ-029 With it defined: a sticky bit sets when, at stage 1 with bright=1, two or more sprites are in region and opaque; on stage-1 hCount==0 and vCount==0 collision loads the sticky bit, which clears that same cycle (a simultaneous overlap re-sets it).
REQ-030 Without it, collision SHALL be constant 0 and no sticky logic SHALL be instantiated.

Verification
REQ-031 Reset: rst_l=0 mid-line -> rgb=000 and collision=0 immediately; rgb valid 2 clocks after release.
REQ-032 Sprite 0 at (100,200), pixel 12'hF00, hCount=100, vCount=200 -> sprite_addr_0=0 and rgb=F00 two clocks later; hCount=99 -> sky, B=12.
REQ-033 Sprites 0 and 1 both at (300,300), opaque F00 and 0F0 -> rgb=F00; sprite 0 pixel 00D -> rgb=0F0.
REQ-034 hud_valid=1, hud_pixel=FFF over an opaque sprite -> rgb=FFF; bright=0 -> rgb=000.
REQ-035 COMPOSITOR_COLLISION_EN defined, sprites overlapping opaquely in frame N -> collision=1 from frame N+1 start through frame N+1; no overlap in N+1 -> collision=0 in frame N+2.
REQ-036 Sprite at x=1000 (edge beyond 1023) -> no region wrap, hCount=5 shows background.
